fence_t_seq: RTL and testbench

Parametrised temporal-fence sequencer. It replaces the fixed dcache-only fence.t FSM inside the flush controller with a generic engine. The engine flushes an arbitrary set of microarchitectural channels (caches, TLBs, branch predictors, and so on) over per-channel req/ack handshakes, then holds a configurable microarchitectural reset pulse. It can optionally pad the whole sequence to a fixed latency, so fence.t duration does not depend on microarchitectural state. It sits beside the flush controller, which forwards decoded fence.t requests and consumes `halt_o`, `rst_uarch_no` and `rst_addr_o`.

---
 rtl/fence_t_seq_pkg.sv | 19 +
 rtl/fence_t_seq_if.sv | 35 +++
 rtl/fence_t_seq.sv | 119 +++++++++++
 tb/tb_fence_t_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fence_t_seq_pkg.sv
// Shared types for the temporal-fence sequencer.
// Holds the FSM state enum and the flush-channel index map.
package fence_t_seq_pkg;

   localparam int unsigned FT_VLEN = 64;

   localparam int unsigned FT_CH_DCACHE = 0;
   localparam int unsigned FT_CH_ICACHE = 1;
   localparam int unsigned FT_CH_TLB    = 2;
   localparam int unsigned FT_CH_BP     = 3;

   typedef enum logic [1:0] {
      FT_IDLE,
      FT_FLUSH,
      FT_RST,
      FT_PAD
   } fence_t_state_e;

endpackage

// File: rtl/fence_t_seq_if.sv
// Request / flush / reset bundle between the flush controller
// (master) and the fence.t sequencer (slave).
interface fence_t_seq_if
   import fence_t_seq_pkg::*;
#(
   parameter int unsigned NumCh = 4,
   parameter int unsigned VLEN  = FT_VLEN
);

   logic             fence_t_valid_i;
   logic [NumCh-1:0] fence_t_mask_i;
   logic             fence_t_pad_i;
   logic [VLEN-1:0]  pc_commit_i;
   logic [NumCh-1:0] flush_req_o;
   logic [NumCh-1:0] flush_ack_i;
   logic             rst_uarch_no;
   logic [VLEN-1:0]  rst_addr_o;
   logic             halt_o;
   logic             overrun_o;

   modport master (
      output fence_t_valid_i, fence_t_mask_i, fence_t_pad_i,
      output pc_commit_i, flush_ack_i,
      input  flush_req_o, rst_uarch_no, rst_addr_o,
      input  halt_o, overrun_o
   );

   modport slave (
      input  fence_t_valid_i, fence_t_mask_i, fence_t_pad_i,
      input  pc_commit_i, flush_ack_i,
      output flush_req_o, rst_uarch_no, rst_addr_o,
      output halt_o, overrun_o
   );

endinterface

// File: rtl/fence_t_seq.sv
// Temporal-fence sequencer: flushes masked channels, pulses the
// uarch reset, then optionally pads the fence to a fixed length.
module fence_t_seq
   import fence_t_seq_pkg::*;
#(
   parameter int unsigned NumCh     = 4,
   parameter int unsigned RstCycles = 16,
   parameter int unsigned PadCycles = 256,
   parameter int unsigned VLEN      = FT_VLEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [VLEN-1:0] boot_addr_i,
   fence_t_seq_if.slave    ft
);

   localparam int unsigned TW = $clog2(PadCycles + 1);
   localparam int unsigned RW = $clog2(RstCycles + 1);

   localparam logic [TW-1:0] PAD_LAST = TW'(PadCycles - 1);
   localparam logic [TW-1:0] PAD_SAT  = TW'(PadCycles);
   localparam logic [RW-1:0] RST_LAST = RW'(RstCycles - 1);

   fence_t_state_e   state_q, state_d;
   logic [NumCh-1:0] pend_q, pend_d;
   logic             pad_q, pad_d;
   logic [VLEN-1:0]  rst_addr_q, rst_addr_d;
   logic [TW-1:0]    tot_cnt_q, tot_cnt_d;
   logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
   logic             overrun_q, overrun_d;

   logic accept;
   logic in_flush;

   assign accept   = (state_q == FT_IDLE) & ft.fence_t_valid_i;
   assign in_flush = (state_q == FT_FLUSH);

   // An ack only retires a channel that is still pending.
   for (genvar i = 0; i < NumCh; i++) begin : g_ch
      assign pend_d[i] = accept   ? ft.fence_t_mask_i[i] :
                         in_flush ? pend_q[i] & ~ft.flush_ack_i[i] :
                                    pend_q[i];
   end

   always_comb begin
      state_d    = state_q;
      pad_d      = pad_q;
      rst_addr_d = rst_addr_q;
      rst_cnt_d  = rst_cnt_q;
      overrun_d  = 1'b0;
      tot_cnt_d  = tot_cnt_q;
      if (state_q != FT_IDLE && tot_cnt_q != PAD_SAT) begin
         tot_cnt_d = tot_cnt_q + TW'(1);
      end
      unique case (state_q)
         FT_IDLE: begin
            if (ft.fence_t_valid_i) begin
               state_d    = FT_FLUSH;
               pad_d      = ft.fence_t_pad_i;
               rst_addr_d = ft.pc_commit_i + VLEN'(4);
               tot_cnt_d  = '0;
            end
         end
         FT_FLUSH: begin
            if (pend_d == '0) begin
               state_d = FT_RST;
            end
         end
         FT_RST: begin
            if (rst_cnt_q == RST_LAST) begin
               rst_cnt_d = '0;
               if (pad_q && tot_cnt_q >= PAD_LAST) begin
                  state_d   = FT_IDLE;
                  overrun_d = 1'b1;
               end else if (pad_q) begin
                  state_d = FT_PAD;
               end else begin
                  state_d = FT_IDLE;
               end
            end else begin
               rst_cnt_d = rst_cnt_q + RW'(1);
            end
         end
         FT_PAD: begin
            if (tot_cnt_q >= PAD_LAST) begin
               state_d = FT_IDLE;
            end
         end
         default: state_d = FT_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= FT_IDLE;
         pend_q     <= '0;
         pad_q      <= 1'b0;
         rst_addr_q <= boot_addr_i;
         tot_cnt_q  <= '0;
         rst_cnt_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pad_q      <= pad_d;
         rst_addr_q <= rst_addr_d;
         tot_cnt_q  <= tot_cnt_d;
         rst_cnt_q  <= rst_cnt_d;
         overrun_q  <= overrun_d;
      end
   end

   assign ft.flush_req_o  = in_flush ? pend_q : '0;
   assign ft.rst_uarch_no = (state_q != FT_RST);
   assign ft.halt_o       = (state_q != FT_IDLE);
   assign ft.overrun_o    = overrun_q;
   assign ft.rst_addr_o   = rst_addr_q;

endmodule

// File: tb/tb_fence_t_seq.sv
// Bench for fence_t_seq: two instances (PadCycles 256 and 32) share
// stimulus and are checked cycle by cycle against a timeline model.
module tb_fence_t_seq;

   localparam int R  = 16;
   localparam int PA = 256;
   localparam int PB = 32;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [63:0] boot_addr;

   int total = 0;
   int bad   = 0;

   fence_t_seq_if #(.NumCh(4), .VLEN(64)) ifa ();
   fence_t_seq_if #(.NumCh(4), .VLEN(64)) ifb ();

   fence_t_seq #(
      .NumCh(4), .RstCycles(R), .PadCycles(PA), .VLEN(64)
   ) dut_a (
      .clk_i(clk_i), .rst_i(rst_i), .boot_addr_i(boot_addr), .ft(ifa)
   );

   fence_t_seq #(
      .NumCh(4), .RstCycles(R), .PadCycles(PB), .VLEN(64)
   ) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .boot_addr_i(boot_addr), .ft(ifb)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] m,
                        input logic p, input logic [63:0] pc,
                        input logic [3:0] ack);
      ifa.fence_t_valid_i = v;
      ifb.fence_t_valid_i = v;
      ifa.fence_t_mask_i  = m;
      ifb.fence_t_mask_i  = m;
      ifa.fence_t_pad_i   = p;
      ifb.fence_t_pad_i   = p;
      ifa.pc_commit_i     = pc;
      ifb.pc_commit_i     = pc;
      ifa.flush_ack_i     = ack;
      ifb.flush_ack_i     = ack;
   endtask

   // Fence timeline: requests live until their ack cycle, the reset
   // window follows the last ack, halt covers flush+reset or PadCycles.
   task automatic run_txn(input string tag, input logic [3:0] mask,
                          input bit pad, input logic [63:0] pc,
                          input int a0, input int a1, input int a2,
                          input int a3, input int rep_ch,
                          input int rep_k, input bit noise);
      int at[4];
      int pp[2];
      int e[2];
      bit ov[2];
      int f, emin, emax;
      logic [3:0]  ack, oreq, xreq;
      logic        orstn, ohalt, oovr, xrstn, xhalt, xovr;
      logic [63:0] oaddr, xaddr;
      at[0] = a0; at[1] = a1; at[2] = a2; at[3] = a3;
      pp[0] = PA; pp[1] = PB;
      f = 1;
      for (int i = 0; i < 4; i++)
         if (mask[i] && at[i] > f) f = at[i];
      for (int d = 0; d < 2; d++) begin
         ov[d] = pad && (f + R >= pp[d]);
         e[d]  = (!pad || ov[d]) ? f + R : pp[d];
      end
      emin  = (e[0] < e[1]) ? e[0] : e[1];
      emax  = ((e[0] > e[1]) ? e[0] : e[1]) + 1;
      xaddr = pc + 64'd4;
      drive(1'b1, mask, pad, pc, 4'b0);
      for (int k = 1; k <= emax; k++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            if (k <= e[d] + 1) begin
               oreq  = d ? ifb.flush_req_o  : ifa.flush_req_o;
               orstn = d ? ifb.rst_uarch_no : ifa.rst_uarch_no;
               ohalt = d ? ifb.halt_o       : ifa.halt_o;
               oovr  = d ? ifb.overrun_o    : ifa.overrun_o;
               oaddr = d ? ifb.rst_addr_o   : ifa.rst_addr_o;
               for (int i = 0; i < 4; i++)
                  xreq[i] = mask[i] && (k <= at[i]);
               xrstn = !(k > f && k <= f + R);
               xhalt = (k <= e[d]);
               xovr  = ov[d] && (k == e[d] + 1);
               total += 5;
               if (oreq !== xreq) begin
                  bad++;
                  $display("FAIL %s dut%0d T%0d flush_req got %b want %b",
                           tag, d, k, oreq, xreq);
               end
               if (orstn !== xrstn) begin
                  bad++;
                  $display("FAIL %s dut%0d T%0d rst_uarch_no got %b want %b",
                           tag, d, k, orstn, xrstn);
               end
               if (ohalt !== xhalt) begin
                  bad++;
                  $display("FAIL %s dut%0d T%0d halt got %b want %b",
                           tag, d, k, ohalt, xhalt);
               end
               if (oovr !== xovr) begin
                  bad++;
                  $display("FAIL %s dut%0d T%0d overrun got %b want %b",
                           tag, d, k, oovr, xovr);
               end
               if (oaddr !== xaddr) begin
                  bad++;
                  $display("FAIL %s dut%0d T%0d rst_addr got %h want %h",
                           tag, d, k, oaddr, xaddr);
               end
            end
         end
         for (int i = 0; i < 4; i++) begin
            ack[i] = (mask[i] && k == at[i]) ||
                     (rep_ch == i && k == rep_k) ||
                     (noise && (!mask[i] || k > at[i]) &&
                      ($urandom_range(3) == 0));
         end
         if (k == emax) ack = 4'b0;
         if (noise && k <= emin && $urandom_range(2) == 0)
            drive(1'b1, 4'($urandom), 1'($urandom),
                  {$urandom, $urandom}, ack);
         else
            drive(1'b0, 4'b0, 1'b0, 64'h0, ack);
      end
   endtask

   task automatic test_reset();
      rst_i     = 1'b1;
      boot_addr = 64'h0000_0000_0001_0000;
      drive(1'b0, 4'b0, 1'b0, 64'h0, 4'b0);
      step();
      step();
      total += 5;
      if (ifa.flush_req_o !== 4'b0) begin
         bad++;
         $display("FAIL reset flush_req got %b want 0000", ifa.flush_req_o);
      end
      if (ifa.rst_uarch_no !== 1'b1) begin
         bad++;
         $display("FAIL reset rst_uarch_no got %b want 1", ifa.rst_uarch_no);
      end
      if (ifa.halt_o !== 1'b0) begin
         bad++;
         $display("FAIL reset halt got %b want 0", ifa.halt_o);
      end
      if (ifb.overrun_o !== 1'b0) begin
         bad++;
         $display("FAIL reset overrun got %b want 0", ifb.overrun_o);
      end
      if (ifb.rst_addr_o !== boot_addr) begin
         bad++;
         $display("FAIL reset rst_addr got %h want %h",
                  ifb.rst_addr_o, boot_addr);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_single();
      run_txn("single", 4'b0001, 1'b0, 64'h8000_0000,
              5, 0, 0, 0, -1, 0, 1'b0);
   endtask

   task automatic test_all_ch();
      run_txn("all_ch", 4'b1111, 1'b0, 64'h8000_1000,
              7, 3, 9, 2, 3, 4, 1'b0);
   endtask

   task automatic test_pad_empty();
      run_txn("pad_empty", 4'b0000, 1'b1, 64'h8000_2000,
              0, 0, 0, 0, -1, 0, 1'b0);
   endtask

   task automatic test_overrun();
      run_txn("overrun", 4'b0001, 1'b1, 64'h8000_3000,
              40, 0, 0, 0, -1, 0, 1'b0);
   endtask

   task automatic test_wrap();
      run_txn("wrap", 4'b0100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE,
              0, 0, 3, 0, -1, 0, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [63:0] nb;
      drive(1'b1, 4'b0010, 1'b0, 64'h8000_4000, 4'b0);
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 5) begin
            total++;
            if (ifa.rst_uarch_no !== 1'b0) begin
               bad++;
               $display("FAIL rst_mid T5 rst_uarch_no got %b want 0",
                        ifa.rst_uarch_no);
            end
         end
         drive(k >= 5, 4'b1111, 1'b1, 64'h9000_0000,
               (k == 2) ? 4'b0010 : 4'b0000);
      end
      nb        = {$urandom, $urandom};
      boot_addr = nb;
      rst_i     = 1'b1;
      step();
      rst_i = 1'b0;
      drive(1'b0, 4'b0, 1'b0, 64'h0, 4'b0);
      for (int j = 0; j < 4; j++) begin
         total += 5;
         if (ifa.flush_req_o !== 4'b0 || ifb.flush_req_o !== 4'b0) begin
            bad++;
            $display("FAIL rst_mid +%0d flush_req got %b/%b want 0000",
                     j, ifa.flush_req_o, ifb.flush_req_o);
         end
         if (ifa.rst_uarch_no !== 1'b1 || ifb.rst_uarch_no !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid +%0d rst_uarch_no got %b/%b want 1",
                     j, ifa.rst_uarch_no, ifb.rst_uarch_no);
         end
         if (ifa.halt_o !== 1'b0 || ifb.halt_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid +%0d halt got %b/%b want 0",
                     j, ifa.halt_o, ifb.halt_o);
         end
         if (ifa.overrun_o !== 1'b0 || ifb.overrun_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid +%0d overrun got %b/%b want 0",
                     j, ifa.overrun_o, ifb.overrun_o);
         end
         if (ifa.rst_addr_o !== nb || ifb.rst_addr_o !== nb) begin
            bad++;
            $display("FAIL rst_mid +%0d rst_addr got %h/%h want %h",
                     j, ifa.rst_addr_o, ifb.rst_addr_o, nb);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      run_txn("b2b0", 4'b1010, 1'b0, 64'h8000_5000,
              0, 2, 0, 1, -1, 0, 1'b1);
      run_txn("b2b1", 4'b0000, 1'b0, 64'h8000_6000,
              0, 0, 0, 0, -1, 0, 1'b1);
      run_txn("b2b2", 4'b0110, 1'b1, 64'h8000_7000,
              0, 4, 1, 0, -1, 0, 1'b1);
      run_txn("b2b3", 4'b1001, 1'b0, 64'h8000_8000,
              3, 0, 0, 3, -1, 0, 1'b1);
   endtask

   task automatic test_random();
      logic [3:0]  m;
      logic [63:0] pc;
      bit          p;
      int          a[4];
      for (int n = 0; n < 24; n++) begin
         m  = 4'($urandom);
         p  = ($urandom_range(3) == 0);
         pc = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                       : {$urandom, $urandom};
         for (int i = 0; i < 4; i++)
            a[i] = ($urandom_range(5) == 0) ? $urandom_range(40, 12)
                                            : $urandom_range(12, 1);
         run_txn("random", m, p, pc, a[0], a[1], a[2], a[3],
                 -1, 0, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_ch();
      test_pad_empty();
      test_overrun();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
